cpu_step_controller: RTL

CPU_STEP_CONTROLLER -- requirements
Module: cpu_step_controller

---
 rtl/cpu_step_pkg.sv | 15 +
 rtl/step_debouncer.sv | 70 +++++++
 rtl/cpu_step_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu_step_pkg.sv
// Shared definitions for the CPU step controller: FSM state encoding and
// default parameter values used by the controller and its debouncer.
package cpu_step_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } stepState_t;

  localparam int unsigned DEFAULT_DEBOUNCE_TICKS = 4;
  localparam int unsigned DEFAULT_CNT_W          = 32;

endpackage

// File: rtl/step_debouncer.sv
// Two-flop synchronizer plus tick-paced debouncer for the raw single-step
// pushbutton. Emits a one-cycle pulse when the debounced level rises.
module step_debouncer
  import cpu_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
  input  logic FPGAClock,
  input  logic FPGAResetN,
  input  logic FPGATick,
  input  logic raw,
  output logic rise
);

  localparam logic [3:0] LAST_COUNT = 4'(DEBOUNCE_TICKS - 1);

  logic       rawMeta_q;
  logic       rawSync_q;
  logic       debounced_q, debounced_d;
  logic [3:0] count_q, count_d;
  logic       rise_q, rise_d;

  // Bring the asynchronous button level into the clock domain
  always_ff @(posedge FPGAClock or negedge FPGAResetN) begin
    if (!FPGAResetN) begin
      rawMeta_q <= 1'b0;
      rawSync_q <= 1'b0;
    end else begin
      rawMeta_q <= raw;
      rawSync_q <= rawMeta_q;
    end
  end

  // Count consecutive tick samples that disagree with the accepted level;
  // any agreeing tick sample restarts the count
  always_comb begin
    debounced_d = debounced_q;
    count_d     = count_q;
    rise_d      = 1'b0;
    if (FPGATick) begin
      if (rawSync_q != debounced_q) begin
        if (count_q == LAST_COUNT) begin
          debounced_d = rawSync_q;
          count_d     = 4'd0;
          rise_d      = rawSync_q;
        end else begin
          count_d = count_q + 4'd1;
        end
      end else begin
        count_d = 4'd0;
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge FPGAClock or negedge FPGAResetN) begin
    if (!FPGAResetN) begin
      debounced_q <= 1'b0;
      count_q     <= 4'd0;
      rise_q      <= 1'b0;
    end else begin
      debounced_q <= debounced_d;
      count_q     <= count_d;
      rise_q      <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/cpu_step_controller.sv
// Run/halt/single-step controller producing a one-cycle clock enable for a
// single-cycle CPU, paced by FPGATick. Define STEP_CTRL_CYCLE_COUNT_EN to
// build the cpu_ce pulse counter; otherwise cycle_count is tied to zero.
module cpu_step_controller
  import cpu_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
  input  logic             FPGAClock,
  input  logic             FPGAResetN,
  input  logic             FPGATick,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  logic       runMeta_q;
  logic       runSync_q;
  logic       stepRise;
  logic       stepPending_q, stepPending_d;
  stepState_t state_q, state_d;
  logic       cpuCe_q, cpuCe_d;
  logic       ceAllowed;

  step_debouncer #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_stepDebouncer (
    .FPGAClock (FPGAClock),
    .FPGAResetN(FPGAResetN),
    .FPGATick  (FPGATick),
    .raw       (step_btn),
    .rise      (stepRise)
  );

  // Synchronize the run switch before the FSM looks at it
  always_ff @(posedge FPGAClock or negedge FPGAResetN) begin
    if (!FPGAResetN) begin
      runMeta_q <= 1'b0;
      runSync_q <= 1'b0;
    end else begin
      runMeta_q <= run_sw;
      runSync_q <= runMeta_q;
    end
  end

  // A tick right after an issued enable is refused so cpu_ce never
  // stays high for two cycles even if ticks arrive back to back
  assign ceAllowed = FPGATick && !cpuCe_q;

  // Next-state, enable and step-request logic
  always_comb begin
    state_d       = state_q;
    cpuCe_d       = 1'b0;
    stepPending_d = stepPending_q | stepRise;
    case (state_q)
      HALT: begin
        if (runSync_q) begin
          state_d       = RUN;
          stepPending_d = 1'b0;
        end else if (stepPending_q) begin
          state_d = STEP;
        end
      end
      RUN: begin
        if (halt_req) begin
          state_d = BREAK;
        end else if (!runSync_q) begin
          state_d = HALT;
        end else if (ceAllowed) begin
          cpuCe_d = 1'b1;
        end
      end
      STEP: begin
        if (ceAllowed) begin
          cpuCe_d       = 1'b1;
          stepPending_d = 1'b0;
          state_d       = HALT;
        end
      end
      BREAK: begin
        stepPending_d = 1'b0;
        if (!runSync_q) begin
          state_d = HALT;
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // FSM, enable and pending-step registers
  always_ff @(posedge FPGAClock or negedge FPGAResetN) begin
    if (!FPGAResetN) begin
      state_q       <= HALT;
      cpuCe_q       <= 1'b0;
      stepPending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cpuCe_q       <= cpuCe_d;
      stepPending_q <= stepPending_d;
    end
  end

  assign cpu_ce = cpuCe_q;
  assign state  = state_q;
  assign halted = (state_q == HALT) || (state_q == BREAK);

`ifdef STEP_CTRL_CYCLE_COUNT_EN
  logic [CNT_W-1:0] count_q;

  // Count issued enables, wrapping naturally at the counter width
  always_ff @(posedge FPGAClock or negedge FPGAResetN) begin
    if (!FPGAResetN) begin
      count_q <= '0;
    end else if (cpuCe_q) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign cycle_count = count_q;
`else
  assign cycle_count = '0;
`endif

endmodule
